// File: rtl/acorn_step_unit.sv
// ACORN-128 state-update engine: advances the 293-bit state by STEPS cipher steps per accepted beat.
// Latency: one cycle; a beat accepted at edge N shows its output and new state after edge N.
// Backpressure: in_ready drops while load is high or a held output is not consumed; state and output freeze.
//
// Ports:
//   i_clk, i_rst        clock (rising edge), synchronous active-high reset
//   i_load, i_state_in  direct state load (takes priority over beats)
//   i_in_valid/o_in_ready, i_in_data, i_in_mode, i_in_ca, i_in_cb   input beat
//   o_out_valid/i_out_ready, o_out_data                             output beat
//   o_state_out         current state register
//
// STEPS may be 1, 2, 4, 8, 16 or 32. Bit i of a beat belongs to step i, so
// instances with different STEPS give bit-identical streams.
module acorn_step_unit #(
    parameter int STEPS = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [292:0]     i_state_in,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [STEPS-1:0] i_in_data,
    input  logic [1:0]       i_in_mode,
    input  logic             i_in_ca,
    input  logic             i_in_cb,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [STEPS-1:0] o_out_data,
    output logic [292:0]     o_state_out
);

    // Mode 11 falls through to absorb, same as 00.
    localparam logic [1:0] MODE_ENC = 2'b01;
    localparam logic [1:0] MODE_DEC = 2'b10;

    logic [292:0]     r_state;
    logic             r_out_valid;
    logic [STEPS-1:0] r_out_data;

    logic [292:0]     w_next_state;
    logic [STEPS-1:0] w_beat_out;
    logic             w_accept;

    function automatic logic maj(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

    function automatic logic ch(input logic x, input logic y, input logic z);
        return (x & y) ^ (~x & z);
    endfunction

    // One cipher step. Returns {output_bit, next_state}.
    function automatic logic [293:0] acorn_step(
        input logic [292:0] s,
        input logic         din,
        input logic [1:0]   mode,
        input logic         ca,
        input logic         cb
    );
        logic [292:0] t;
        logic         ks;
        logic         m;
        logic         ob;
        logic         f;
        // Linear pass: every operand comes from the pre-step state s.
        t      = s;
        t[289] = s[289] ^ s[235] ^ s[230];
        t[230] = s[230] ^ s[196] ^ s[193];
        t[193] = s[193] ^ s[160] ^ s[154];
        t[154] = s[154] ^ s[111] ^ s[107];
        t[107] = s[107] ^ s[66]  ^ s[61];
        t[61]  = s[61]  ^ s[23]  ^ s[0];
        // Keystream and feedback read the post-linear state t.
        ks = t[12] ^ t[154] ^ maj(t[235], t[61], t[193]) ^ ch(t[230], t[111], t[66]);
        // Decrypt recovers the plaintext bit before it enters the feedback.
        m  = (mode == MODE_DEC) ? (din ^ ks) : din;
        // Encrypt and decrypt both emit din^ks; absorb emits the raw keystream.
        ob = (mode == MODE_ENC || mode == MODE_DEC) ? (din ^ ks) : ks;
        f  = t[0] ^ ~t[107] ^ maj(t[244], t[23], t[160]) ^ (ca & t[196]) ^ (cb & ks);
        return {ob, f ^ m, t[292:1]};
    endfunction

    // Unrolled chain: step i+1 consumes the state produced by step i.
    always_comb begin
        logic [293:0] w_res;
        w_res        = '0;
        w_next_state = r_state;
        w_beat_out   = '0;
        for (int i = 0; i < STEPS; i++) begin
            w_res         = acorn_step(w_next_state, i_in_data[i], i_in_mode, i_in_ca, i_in_cb);
            w_beat_out[i] = w_res[293];
            w_next_state  = w_res[292:0];
        end
    end

    assign o_in_ready = !i_load && (!r_out_valid || i_out_ready);
    assign w_accept   = i_in_valid && o_in_ready;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else if (i_load) begin
            // Load freezes the output register, even if it is being consumed.
            r_state <= i_state_in;
        end else if (w_accept) begin
            r_state     <= w_next_state;
            r_out_data  <= w_beat_out;
            r_out_valid <= 1'b1;
        end else if (i_out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign o_out_valid = r_out_valid;
    assign o_out_data  = r_out_data;
    assign o_state_out = r_state;

endmodule

// File: tb/tb_acorn_step_unit.sv
module tb_acorn_step_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // Instance a: STEPS=1
    logic         a_load, a_in_valid, a_in_ready, a_in_ca, a_in_cb, a_out_valid, a_out_ready;
    logic [292:0] a_state_in, a_state_out;
    logic [0:0]   a_in_data, a_out_data;
    logic [1:0]   a_in_mode;
    // Instance b: STEPS=8
    logic         b_load, b_in_valid, b_in_ready, b_in_ca, b_in_cb, b_out_valid, b_out_ready;
    logic [292:0] b_state_in, b_state_out;
    logic [7:0]   b_in_data, b_out_data;
    logic [1:0]   b_in_mode;

    acorn_step_unit #(.STEPS(1)) u_a (
        .i_clk(clk), .i_rst(rst), .i_load(a_load), .i_state_in(a_state_in),
        .i_in_valid(a_in_valid), .o_in_ready(a_in_ready), .i_in_data(a_in_data),
        .i_in_mode(a_in_mode), .i_in_ca(a_in_ca), .i_in_cb(a_in_cb),
        .o_out_valid(a_out_valid), .i_out_ready(a_out_ready), .o_out_data(a_out_data),
        .o_state_out(a_state_out)
    );

    acorn_step_unit #(.STEPS(8)) u_b (
        .i_clk(clk), .i_rst(rst), .i_load(b_load), .i_state_in(b_state_in),
        .i_in_valid(b_in_valid), .o_in_ready(b_in_ready), .i_in_data(b_in_data),
        .i_in_mode(b_in_mode), .i_in_ca(b_in_ca), .i_in_cb(b_in_cb),
        .o_out_valid(b_out_valid), .i_out_ready(b_out_ready), .o_out_data(b_out_data),
        .o_state_out(b_state_out)
    );

    int checks = 0;
    int errors = 0;

    // Model state and scoreboards
    logic [292:0] ea_st, eb_st;
    logic         ea_vld, eb_vld;
    logic [7:0]   qa[$], qb[$];          // expected outputs awaiting consumption
    logic [7:0]   capa[$], capb[$];      // DUT outputs captured at consumption
    logic [7:0]   mcapa[$], mcapb[$];    // model outputs in acceptance order

    task automatic check(input string tag, input logic [292:0] obs, input logic [292:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic maj3(input logic x, input logic y, input logic z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

    function automatic logic ch3(input logic x, input logic y, input logic z);
        return (x & y) ^ (~x & z);
    endfunction

    // Reference step; in-place updates in descending order never read an already-updated bit.
    function automatic logic [293:0] ref_step(input logic [292:0] s, input logic d,
                                              input logic [1:0] mode, input logic ca, input logic cb);
        logic ks, m, o, f;
        s[289] = s[289] ^ s[235] ^ s[230];
        s[230] = s[230] ^ s[196] ^ s[193];
        s[193] = s[193] ^ s[160] ^ s[154];
        s[154] = s[154] ^ s[111] ^ s[107];
        s[107] = s[107] ^ s[66] ^ s[61];
        s[61]  = s[61] ^ s[23] ^ s[0];
        ks = s[12] ^ s[154] ^ maj3(s[235], s[61], s[193]) ^ ch3(s[230], s[111], s[66]);
        case (mode)
            2'b01:   begin m = d;      o = d ^ ks; end
            2'b10:   begin m = d ^ ks; o = m;      end
            default: begin m = d;      o = ks;     end
        endcase
        f = s[0] ^ ~s[107] ^ maj3(s[244], s[23], s[160]) ^ (ca & s[196]) ^ (cb & ks);
        s = {f ^ m, s[292:1]};
        return {o, s};
    endfunction

    function automatic logic [300:0] ref_beat(input logic [292:0] s, input logic [7:0] d, input int n,
                                              input logic [1:0] mode, input logic ca, input logic cb);
        logic [7:0]   o;
        logic [293:0] r;
        o = '0;
        for (int i = 0; i < n; i++) begin
            r    = ref_step(s, d[i], mode, ca, cb);
            o[i] = r[293];
            s    = r[292:0];
        end
        return {o, s};
    endfunction

    function automatic logic [292:0] rand293();
        logic [292:0] r;
        for (int i = 0; i < 293; i++) r[i] = 1'($urandom_range(1));
        return r;
    endfunction

    // One clock: at negedge update models (pop on consume, push on accept), after edge check state.
    task automatic tick();
        logic         rdy;
        logic [300:0] r;
        logic [7:0]   e;
        @(negedge clk);
        if (rst) begin
            ea_st = '0; eb_st = '0; ea_vld = 1'b0; eb_vld = 1'b0;
            qa.delete(); qb.delete();
        end else begin
            rdy = !a_load && (!ea_vld || a_out_ready);
            check("a_in_ready", 293'(a_in_ready), 293'(rdy));
            if (a_load) ea_st = a_state_in;
            else begin
                if (ea_vld && a_out_ready) begin
                    e = qa.pop_front();
                    check("a_out_data", 293'(a_out_data), 293'(e));
                    capa.push_back(8'(a_out_data));
                    ea_vld = 1'b0;
                end
                if (rdy && a_in_valid) begin
                    r = ref_beat(ea_st, 8'(a_in_data), 1, a_in_mode, a_in_ca, a_in_cb);
                    ea_st = r[292:0];
                    qa.push_back(r[300:293]);
                    mcapa.push_back(r[300:293]);
                    ea_vld = 1'b1;
                end
            end
            rdy = !b_load && (!eb_vld || b_out_ready);
            check("b_in_ready", 293'(b_in_ready), 293'(rdy));
            if (b_load) eb_st = b_state_in;
            else begin
                if (eb_vld && b_out_ready) begin
                    e = qb.pop_front();
                    check("b_out_data", 293'(b_out_data), 293'(e));
                    capb.push_back(b_out_data);
                    eb_vld = 1'b0;
                end
                if (rdy && b_in_valid) begin
                    r = ref_beat(eb_st, b_in_data, 8, b_in_mode, b_in_ca, b_in_cb);
                    eb_st = r[292:0];
                    qb.push_back(r[300:293]);
                    mcapb.push_back(r[300:293]);
                    eb_vld = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
        check("a_out_valid", 293'(a_out_valid), 293'(ea_vld));
        check("a_state_out", a_state_out, ea_st);
        check("b_out_valid", 293'(b_out_valid), 293'(eb_vld));
        check("b_state_out", b_state_out, eb_st);
    endtask

    logic [292:0] exp_st, x, y, z;
    logic [7:0]   p[8];
    logic         cav[8], cbv[8];
    logic [7:0]   c[$];
    logic [7:0]   bt, mb;
    logic [1:0]   md;
    logic         rca, rcb;

    initial begin
        rst = 1'b1;
        a_load = 0; a_state_in = '0; a_in_valid = 0; a_in_data = '0; a_in_mode = 0;
        a_in_ca = 0; a_in_cb = 0; a_out_ready = 1;
        b_load = 0; b_state_in = '0; b_in_valid = 0; b_in_data = '0; b_in_mode = 0;
        b_in_ca = 0; b_in_cb = 0; b_out_ready = 1;
        ea_st = '0; eb_st = '0; ea_vld = 0; eb_vld = 0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("rst_a_out_data", 293'(a_out_data), '0);
        check("rst_b_out_data", 293'(b_out_data), '0);
        check("rst_a_in_ready", 293'(a_in_ready), 293'(1'b1));
        check("rst_b_in_ready", 293'(b_in_ready), 293'(1'b1));

        // Zero state, absorb 0: only bit 292 set
        a_in_valid = 1; a_in_data = 1'b0; a_in_mode = 2'b00; a_in_ca = 0; a_in_cb = 0;
        tick();
        a_in_valid = 0;
        exp_st = '0; exp_st[292] = 1'b1;
        check("t1_state", a_state_out, exp_st);
        check("t1_out", 293'(a_out_data), '0);
        tick();

        // Only S235 set: bits 292, 288, 234 after one absorb step
        exp_st = '0; exp_st[235] = 1'b1;
        a_load = 1; a_state_in = exp_st;
        tick();
        a_load = 0; a_in_valid = 1;
        tick();
        a_in_valid = 0;
        exp_st = '0; exp_st[292] = 1'b1; exp_st[288] = 1'b1; exp_st[234] = 1'b1;
        check("t2_state", a_state_out, exp_st);
        check("t2_out", 293'(a_out_data), '0);
        tick();

        // Encrypt 64 bits from X, then decrypt from X
        x = rand293();
        b_load = 1; b_state_in = x;
        tick();
        b_load = 0;
        capb.delete();
        for (int k = 0; k < 8; k++) begin
            p[k] = 8'($urandom); cav[k] = 1'($urandom); cbv[k] = 1'($urandom);
            b_in_valid = 1; b_in_data = p[k]; b_in_mode = 2'b01; b_in_ca = cav[k]; b_in_cb = cbv[k];
            tick();
        end
        b_in_valid = 0;
        tick();
        c = capb;
        y = eb_st;
        b_load = 1; b_state_in = x;
        tick();
        b_load = 0;
        capb.delete();
        for (int k = 0; k < 8; k++) begin
            b_in_valid = 1; b_in_data = (k < c.size()) ? c[k] : 8'h00; b_in_mode = 2'b10;
            b_in_ca = cav[k]; b_in_cb = cbv[k];
            tick();
        end
        b_in_valid = 0;
        tick();
        check("dec_count", 293'(capb.size()), 293'(8));
        for (int k = 0; k < 8 && k < capb.size(); k++) check("dec_plain", 293'(capb[k]), 293'(p[k]));
        check("dec_state", b_state_out, y);

        // Equivalence: 256 bits, 1-bit beats on a vs byte beats on b
        x = rand293();
        a_load = 1; b_load = 1; a_state_in = x; b_state_in = x;
        tick();
        a_load = 0; b_load = 0;
        capa.delete(); mcapb.delete();
        bt = '0; md = '0; rca = 0; rcb = 0;
        for (int i = 0; i < 256; i++) begin
            if (i % 8 == 0) begin
                bt = 8'($urandom);
                case ($urandom_range(2))
                    0:       md = 2'b00;
                    1:       md = 2'b01;
                    default: md = 2'b11;
                endcase
                rca = 1'($urandom); rcb = 1'($urandom);
            end
            a_in_valid = 1; a_in_data = bt[i % 8]; a_in_mode = md; a_in_ca = rca; a_in_cb = rcb;
            b_in_valid = (i % 8 == 0); b_in_data = bt; b_in_mode = md; b_in_ca = rca; b_in_cb = rcb;
            tick();
        end
        a_in_valid = 0; b_in_valid = 0;
        tick();
        check("eq_state_a", a_state_out, eb_st);
        check("eq_state_b", b_state_out, ea_st);
        check("eq_count", 293'(capa.size()), 293'(256));
        for (int i = 0; i < 256 && i < capa.size() && (i / 8) < mcapb.size(); i++) begin
            mb = mcapb[i / 8];
            check("eq_bit", 293'(capa[i]), 293'(mb[i % 8]));
        end

        // Backpressure on b
        capb.delete(); mcapb.delete();
        b_out_ready = 0; b_in_valid = 1; b_in_mode = 2'b01; b_in_ca = 0; b_in_cb = 1; b_in_data = 8'h5A;
        tick();
        b_in_data = 8'h3C;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("bp_in_ready", 293'(b_in_ready), '0);
            check("bp_hold_data", 293'(b_out_data), 293'((qb.size() > 0) ? qb[0] : 8'hxx));
        end
        b_out_ready = 1;
        for (int k = 0; k < 4; k++) begin
            b_in_data = 8'h3C + 8'(k * 17);
            tick();
        end
        b_in_valid = 0;
        tick();
        check("bp_count", 293'(capb.size()), 293'(5));
        check("bp_model_count", 293'(mcapb.size()), 293'(5));
        for (int k = 0; k < 5 && k < capb.size() && k < mcapb.size(); k++)
            check("bp_seq", 293'(capb[k]), 293'(mcapb[k]));

        // Load together with in_valid: beat refused, state loaded
        z = rand293();
        b_load = 1; b_state_in = z; b_in_valid = 1; b_in_data = 8'hC3; b_in_mode = 2'b00;
        tick();
        check("ld_in_ready", 293'(b_in_ready), '0);
        check("ld_state", b_state_out, z);
        b_load = 0;
        tick();
        tick();

        // Reset mid-stream, with load also high
        rst = 1; b_load = 1;
        tick();
        check("rst_mid_valid", 293'(b_out_valid), '0);
        check("rst_mid_state", b_state_out, '0);
        rst = 0; b_load = 0; b_in_valid = 0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
